// File: rtl/acc_sequencer.sv
// acc_sequencer: walks a term-memory address range and feeds each term
// (with its add/sub flag) into a 2-stage signed accumulator. Init is
// aligned with the first term. The pipeline is drained, the sum is
// captured and oDone pulses.
// Optional feature macro ACC_SEQ_CLAMP_EN: the captured sum saturates to
// the signed WIDTH_RES range and the oSat port is added.
module acc_sequencer #(
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_ACC  = 24,
  parameter int WIDTH_ADDR = 10,
  parameter int WIDTH_LEN  = 10,
  parameter int WIDTH_RES  = 16
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  iStart,
  input  logic                  iAbort,
  input  logic [WIDTH_ADDR-1:0] iBase,
  input  logic [WIDTH_LEN-1:0]  iLen,
  output logic                  oRdEn,
  output logic [WIDTH_ADDR-1:0] oRdAddr,
  input  logic [WIDTH_DATA-1:0] iRdData,
  input  logic                  iRdSub,
  output logic                  oAccInit,
  output logic                  oAccValid,
  output logic                  oAccSub,
  output logic [WIDTH_DATA-1:0] oAccData,
  input  logic [WIDTH_ACC-1:0]  iAccData,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [WIDTH_RES-1:0]  oResult
`ifdef ACC_SEQ_CLAMP_EN
  ,
  output logic                  oSat
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ZERO  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [WIDTH_ADDR-1:0] base_q;
  logic [WIDTH_LEN-1:0]  len_q;
  logic [WIDTH_LEN-1:0]  cnt;
  logic [1:0]            drain_cnt;
  // [0]: read issued this cycle, [1]: its data is at the accumulator
  logic [1:0]            vld_pipe;
  logic [1:0]            init_pipe;
  logic [WIDTH_ADDR-1:0] rd_addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic [WIDTH_RES-1:0]  result_q;
  logic [WIDTH_RES-1:0]  res_nxt;

  logic accept, issue, zero_ld, finish, abort_act, cnt_last;

  assign abort_act = iAbort && (state != S_IDLE);
  assign cnt_last  = (cnt == len_q - WIDTH_LEN'(1));

  // State register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state and per-cycle control strobes; abort overrides everything
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    zero_ld   = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (iStart && !iAbort) begin
          accept    = 1'b1;
          state_nxt = (iLen == '0) ? S_ZERO : S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (cnt_last) state_nxt = S_DRAIN;
      end
      S_ZERO: begin
        zero_ld   = 1'b1;
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == 2'd1) state_nxt = S_DONE;
      end
      S_DONE: begin
        finish    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_act) begin
      state_nxt = S_IDLE;
      issue     = 1'b0;
      zero_ld   = 1'b0;
      finish    = 1'b0;
    end
  end

  // Sequence bookkeeping: latched request, term counter, drain countdown.
  // The empty-sum path drains one cycle less: there is no memory read to cover.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      base_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        base_q <= iBase;
        len_q  <= iLen;
        cnt    <= '0;
      end else if (issue) begin
        cnt <= cnt + WIDTH_LEN'(1);
      end
      if (issue && cnt_last)  drain_cnt <= 2'd3;
      else if (zero_ld)       drain_cnt <= 2'd2;
      else if (state == S_DRAIN) drain_cnt <= drain_cnt - 2'd1;
    end
  end

  // Read issue and accumulator control pipeline; abort flushes it in one cycle
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vld_pipe  <= '0;
      init_pipe <= '0;
      rd_addr_q <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[0] & ~abort_act, issue};
      init_pipe <= {(init_pipe[0] & ~abort_act) | zero_ld, issue & (cnt == '0)};
      if (issue) rd_addr_q <= base_q + WIDTH_ADDR'(cnt);
    end
  end

`ifdef ACC_SEQ_CLAMP_EN
  localparam logic signed [WIDTH_ACC-1:0] RES_MAX =
    {{(WIDTH_ACC-WIDTH_RES+1){1'b0}}, {(WIDTH_RES-1){1'b1}}};
  localparam logic signed [WIDTH_ACC-1:0] RES_MIN = ~RES_MAX;

  logic sat_nxt;
  logic sat_q;

  // Saturate the signed accumulator value into the result range
  always_comb begin
    res_nxt = iAccData[WIDTH_RES-1:0];
    sat_nxt = 1'b0;
    if ($signed(iAccData) > RES_MAX) begin
      res_nxt = RES_MAX[WIDTH_RES-1:0];
      sat_nxt = 1'b1;
    end else if ($signed(iAccData) < RES_MIN) begin
      res_nxt = RES_MIN[WIDTH_RES-1:0];
      sat_nxt = 1'b1;
    end
  end

  // Saturation flag pulses with oDone
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) sat_q <= 1'b0;
    else         sat_q <= finish & sat_nxt;
  end

  assign oSat = sat_q;
`else
  assign res_nxt = iAccData[WIDTH_RES-1:0];

  generate
    if (WIDTH_RES < WIDTH_ACC) begin : g_trunc
      logic acc_hi_unused;
      assign acc_hi_unused = ^iAccData[WIDTH_ACC-1:WIDTH_RES];
    end
  endgenerate
`endif

  // Busy window, done pulse and result capture
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept)                  busy_q <= 1'b1;
      else if (done_q || abort_act) busy_q <= 1'b0;
      done_q <= finish;
      if (finish) result_q <= res_nxt;
    end
  end

  assign oRdEn     = vld_pipe[0];
  assign oRdAddr   = rd_addr_q;
  assign oAccValid = vld_pipe[1];
  assign oAccInit  = init_pipe[1];
  assign oAccData  = vld_pipe[1] ? iRdData : '0;
  assign oAccSub   = vld_pipe[1] & iRdSub;
  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oResult   = result_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: term memory and accumulator models around the
// DUT, a transaction-level reference model checked every cycle, directed
// literal cases and a randomized run.
module tb_acc_sequencer;

  logic        iCLK, iRST_n, iStart, iAbort;
  logic [9:0]  iBase, iLen;
  logic        oRdEn;
  logic [9:0]  oRdAddr;
  logic [15:0] iRdData;
  logic        iRdSub;
  logic        oAccInit, oAccValid, oAccSub;
  logic [15:0] oAccData;
  logic [23:0] iAccData;
  logic        oBusy, oDone;
  logic [15:0] oResult;
`ifdef ACC_SEQ_CLAMP_EN
  logic        oSat;
`endif

  acc_sequencer dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iAbort(iAbort),
    .iBase(iBase), .iLen(iLen), .oRdEn(oRdEn), .oRdAddr(oRdAddr),
    .iRdData(iRdData), .iRdSub(iRdSub), .oAccInit(oAccInit),
    .oAccValid(oAccValid), .oAccSub(oAccSub), .oAccData(oAccData),
    .iAccData(iAccData), .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
`ifdef ACC_SEQ_CLAMP_EN
    , .oSat(oSat)
`endif
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // term memory, 1-cycle read latency
  logic [15:0] mem  [1024];
  logic        msub [1024];
  always @(posedge iCLK) begin
    iRdData <= mem[oRdAddr];
    iRdSub  <= msub[oRdAddr];
  end

  // accumulator: two register stages, never reset, starts with junk
  logic signed [23:0] acc_r = 24'h5A5A5A;
  logic signed [23:0] acc_q = 24'h123456;
  logic signed [23:0] acc_d;
  assign acc_d = {{8{oAccData[15]}}, oAccData};
  always @(posedge iCLK) begin
    if (oAccInit)       acc_r <= oAccValid ? (oAccSub ? -acc_d : acc_d) : 24'sd0;
    else if (oAccValid) acc_r <= oAccSub ? acc_r - acc_d : acc_r + acc_d;
    acc_q <= acc_r;
  end
  assign iAccData = acc_q;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, a, e);
    end
  endtask

  function automatic int term_val(input int a);
    return int'($signed(mem[a]));
  endfunction

  function automatic logic [15:0] res_of(input int s);
    logic [31:0] v;
    v = s;
`ifdef ACC_SEQ_CLAMP_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  function automatic bit sat_of(input int s);
    return (s > 32767) || (s < -32768);
  endfunction

  // reference model: one transaction described by its start cycle and terms
  bit          act = 0;
  int          t0 = 0, m_base = 0, m_len = 0, m_sum = 0;
  logic [15:0] exp_res = '0;
  bit          exp_sat = 0;

  initial begin
    forever begin : cmp
      int k, a;
      bit e_rd, e_val, e_init, e_busy, e_done;
      @(negedge iCLK);
      if (!iRST_n) begin
        act = 0; exp_res = '0; exp_sat = 0;
      end else begin
        k      = cyc - t0;
        e_rd   = act && m_len > 0 && k >= 2 && k <= m_len + 1;
        e_val  = act && m_len > 0 && k >= 3 && k <= m_len + 2;
        e_init = act && ((m_len > 0) ? (k == 3) : (k == 2));
        e_busy = act && k >= 1 && k <= m_len + 5;
        e_done = act && k == m_len + 5;
        if (e_done) begin
          exp_res = res_of(m_sum);
          exp_sat = sat_of(m_sum);
        end
        chk("rd_en", 32'(oRdEn), 32'(e_rd));
        if (e_rd) chk("rd_addr", 32'(oRdAddr), (m_base + k - 2) % 1024);
        chk("acc_valid", 32'(oAccValid), 32'(e_val));
        chk("acc_init", 32'(oAccInit), 32'(e_init));
        a = (m_base + k - 3) % 1024;
        chk("acc_data", 32'(oAccData), e_val ? 32'(mem[a]) : 32'd0);
        chk("acc_sub", 32'(oAccSub), e_val ? 32'(msub[a]) : 32'd0);
        chk("busy", 32'(oBusy), 32'(e_busy));
        chk("done", 32'(oDone), 32'(e_done));
        chk("result", 32'(oResult), 32'(exp_res));
`ifdef ACC_SEQ_CLAMP_EN
        chk("sat", 32'(oSat), 32'(e_done && exp_sat));
`endif
        // transitions taken at the coming edge
        if (act && k >= 1 && k <= m_len + 4 && iAbort) begin
          act = 0;
        end else if ((!act || k >= m_len + 5) && iStart && !iAbort) begin
          act = 1; t0 = cyc; m_base = int'(iBase); m_len = int'(iLen); m_sum = 0;
          for (int i = 0; i < m_len; i++) begin
            a = (m_base + i) % 1024;
            if (msub[a]) m_sum -= term_val(a);
            else         m_sum += term_val(a);
          end
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  int addrs[$];
  int done_k, busy_n, rd_n, init_n;

  // start one sequence and observe it until oDone (bounded)
  task automatic run_txn(input int base, input int len, input bit stray);
    iStart = 1'b1; iBase = 10'(base); iLen = 10'(len);
    tick();
    iStart = 1'b0;
    done_k = -1; busy_n = 0; rd_n = 0; init_n = 0; addrs.delete();
    for (int k = 1; k <= 60; k++) begin
      if (oBusy) busy_n++;
      if (oRdEn) begin rd_n++; addrs.push_back(int'(oRdAddr)); end
      if (oAccInit && (oAccValid || len == 0)) init_n++;
      if (oDone) begin done_k = k; break; end
      if (stray && k == 3) begin
        iStart = 1'b1; iBase = 10'(500); iLen = 10'(3);
      end else iStart = 1'b0;
      tick();
    end
    iStart = 1'b0;
    if (done_k < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int exp_a[4];
    exp_a = '{1022, 1023, 0, 1};
    iRST_n = 1'b0; iStart = 1'b0; iAbort = 1'b0; iBase = '0; iLen = '0;
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; msub[i] = 1'b0; end
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_rd_en", 32'(oRdEn), 0);
    chk("rst_result", 32'(oResult), 0);
    iRST_n = 1'b1;
    tick();

    // 4 terms, all adds
    mem[0] = 16'd10; mem[1] = 16'd20; mem[2] = 16'd30; mem[3] = 16'd40;
    run_txn(0, 4, 0);
    chk("t1_done_k", done_k, 9);
    chk("t1_busy_n", busy_n, 9);
    chk("t1_result", 32'(oResult), 100);

    // mixed signs and sub flag
    tick();
    mem[100] = 16'd100; mem[101] = 16'hFFFB; mem[102] = 16'd7;
    msub[101] = 1'b1;
    run_txn(100, 3, 0);
    chk("t2_done_k", done_k, 8);
    chk("t2_result", 32'(oResult), 112);
    chk("t2_init_n", init_n, 1);

    // back-to-back with a stray start mid-sequence
    tick();
    mem[50] = 16'd1; mem[51] = 16'd1;
    run_txn(50, 2, 1);
    chk("t3_done_k", done_k, 7);
    chk("t3_result", 32'(oResult), 2);

    // empty sum
    tick();
    run_txn(700, 0, 0);
    chk("t4_done_k", done_k, 5);
    chk("t4_rd_n", rd_n, 0);
    chk("t4_result", 32'(oResult), 0);

    // address wrap
    tick();
    mem[1022] = 16'd5; mem[1023] = 16'd6; mem[0] = 16'd7; mem[1] = 16'd8;
    run_txn(1022, 4, 0);
    chk("t5_addr_n", addrs.size(), 4);
    if (addrs.size() == 4)
      for (int i = 0; i < 4; i++) chk("t5_addr", addrs[i], exp_a[i]);
    chk("t5_result", 32'(oResult), 26);

    // abort on the second issue cycle
    tick();
    iStart = 1'b1; iBase = 10'd200; iLen = 10'd8;
    tick(); iStart = 1'b0;
    tick(); tick();
    chk("t6_rd_before", 32'(oRdEn), 1);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    chk("t6_rd_en", 32'(oRdEn), 0);
    chk("t6_busy", 32'(oBusy), 0);
    chk("t6_valid", 32'(oAccValid), 0);
    chk("t6_init", 32'(oAccInit), 0);
    for (int i = 0; i < 15; i++) begin
      if (oDone) chk("t6_no_done", 32'(oDone), 0);
      tick();
    end
    chk("t6_result", 32'(oResult), 26);

    // abort together with start in idle: start dropped
    iStart = 1'b1; iAbort = 1'b1; iBase = 10'd0; iLen = 10'd2;
    tick();
    iStart = 1'b0; iAbort = 1'b0;
    chk("t7_busy", 32'(oBusy), 0);
    tick();
    chk("t7_rd_en", 32'(oRdEn), 0);

    // reset mid-drain
    mem[300] = 16'd1; mem[301] = 16'd2; mem[302] = 16'd3;
    iStart = 1'b1; iBase = 10'd300; iLen = 10'd3;
    tick(); iStart = 1'b0;
    tick(); tick(); tick();
    #2 iRST_n = 1'b0;
    #1;
    chk("t8_rd_en", 32'(oRdEn), 0);
    chk("t8_busy", 32'(oBusy), 0);
    chk("t8_valid", 32'(oAccValid), 0);
    chk("t8_result", 32'(oResult), 0);
    @(posedge iCLK);
    #1 iRST_n = 1'b1;
    tick();

    // out-of-range sums: truncation, or saturation when clamping
    mem[400] = 16'd20000; mem[401] = 16'd20000;
    run_txn(400, 2, 0);
`ifdef ACC_SEQ_CLAMP_EN
    chk("t9_result_hi", 32'(oResult), 32'h7FFF);
    chk("t9_sat_hi", 32'(oSat), 1);
`else
    chk("t9_result_hi", 32'(oResult), 32'h9C40);
`endif
    tick();
    mem[410] = 16'd20000; mem[411] = 16'd20000; msub[410] = 1'b1; msub[411] = 1'b1;
    run_txn(410, 2, 0);
`ifdef ACC_SEQ_CLAMP_EN
    chk("t9_result_lo", 32'(oResult), 32'h8000);
    chk("t9_sat_lo", 32'(oSat), 1);
`else
    chk("t9_result_lo", 32'(oResult), 32'h63C0);
`endif

    // randomized sequences, stray starts and aborts
    tick();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'($urandom); msub[i] = 1'($urandom);
    end
    for (int t = 0; t < 60; t++) begin
      int len, ab_at, gap;
      len   = int'($urandom_range(0, 12));
      ab_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, len + 4)) : 0;
      gap   = int'($urandom_range(0, 3));
      iStart = 1'b1; iBase = 10'($urandom); iLen = 10'(len);
      tick();
      for (int k = 1; k <= len + 5 + gap; k++) begin
        iAbort = (k == ab_at);
        iStart = ($urandom_range(0, 9) == 0);
        iBase  = 10'($urandom);
        iLen   = 10'($urandom_range(0, 12));
        tick();
      end
      iAbort = 1'b0; iStart = 1'b0;
    end
    repeat (25) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
